// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for a five-stage-style core with IF/ID and ID/EX
// registers. It produces same-cycle hold/flush/bubble controls for load-use
// hazards, EX-stage redirects and data-memory/IO back-pressure. It also keeps
// wrap-around stall and redirect counters for CSR readout.
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,  // ifid_flush cycles per redirect, 1..7
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_inst,
  input  logic [31:0]      ex_inst,
  input  logic             br_taken,
  input  logic             mem_busy,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             ex_hold,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] redirect_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // The redirect cycle itself is the first flush cycle, so FLUSH covers the rest.
  localparam logic [2:0]       FLUSH_INIT  = 3'(FLUSH_CYCLES - 1);
  localparam bit               MULTI_FLUSH = (FLUSH_CYCLES > 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  // rs1 is read by everything except U-types, JAL and the immediate CSR forms.
  function automatic logic uses_rs1(input logic [6:0] op, input logic f3_hi);
    logic used;
    used = 1'b1;
    if (op == OP_LUI || op == OP_AUIPC || op == OP_JAL)
      used = 1'b0;
    else if (op == OP_SYSTEM && f3_hi)
      used = 1'b0;
    return used;
  endfunction

  // rs2 is read only by R-type, stores and conditional branches.
  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_REG) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  state_t     state, state_nxt;
  state_t     ret_state, ret_nxt;
  state_t     eval_state;
  logic [2:0] flush_cnt, flush_cnt_nxt;
  logic       stall_inc;
  logic       redir_inc;

  logic [6:0] ex_op;
  logic [4:0] ex_rd;
  logic [6:0] id_op;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_f3_hi;
  logic       ex_is_load;
  logic       load_use;
  logic       unused_inst_bits;

  assign ex_op    = ex_inst[6:0];
  assign ex_rd    = ex_inst[11:7];
  assign id_op    = id_inst[6:0];
  assign id_rs1   = id_inst[19:15];
  assign id_rs2   = id_inst[24:20];
  assign id_f3_hi = id_inst[14];

  assign unused_inst_bits = ^{id_inst[31:25], id_inst[13:7], ex_inst[31:12]};

  // A load writing x0 never creates a dependency.
  assign ex_is_load = (ex_op == OP_LOAD) && (ex_rd != 5'd0);

  // ID reads a register that the load in EX has not produced yet.
  always_comb begin
    load_use = 1'b0;
    if (ex_is_load) begin
      if (uses_rs1(id_op, id_f3_hi) && (id_rs1 == ex_rd))
        load_use = 1'b1;
      if (uses_rs2(id_op) && (id_rs2 == ex_rd))
        load_use = 1'b1;
    end
  end

  // Next-state and control outputs; mem_busy beats br_taken beats load_use.
  always_comb begin
    pc_hold       = 1'b0;
    ifid_hold     = 1'b0;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    ex_hold       = 1'b0;
    state_nxt     = state;
    ret_nxt       = ret_state;
    flush_cnt_nxt = flush_cnt;
    stall_inc     = 1'b0;
    redir_inc     = 1'b0;
    eval_state    = state;

    // Leaving MEM_WAIT: behave as the resumed state within this same cycle.
    if (state == MEM_WAIT && !mem_busy) begin
      eval_state = ret_state;
      state_nxt  = ret_state;
    end

    case (eval_state)
      RUN: begin
        if (mem_busy) begin
          pc_hold   = 1'b1;
          ifid_hold = 1'b1;
          ex_hold   = 1'b1;
          state_nxt = MEM_WAIT;
          ret_nxt   = RUN;
          stall_inc = 1'b1;
        end else if (br_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          redir_inc   = 1'b1;
          if (MULTI_FLUSH) begin
            flush_cnt_nxt = FLUSH_INIT;
            state_nxt     = FLUSH;
          end
        end else if (load_use) begin
          // One bubble suffices: next cycle EX holds the NOP, not the load.
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
          stall_inc   = 1'b1;
        end
      end

      FLUSH: begin
        if (mem_busy) begin
          // Freeze the flush countdown and resume it once memory is ready.
          pc_hold   = 1'b1;
          ifid_hold = 1'b1;
          ex_hold   = 1'b1;
          state_nxt = MEM_WAIT;
          ret_nxt   = FLUSH;
          stall_inc = 1'b1;
        end else begin
          // EX holds a bubble here, so br_taken and load_use are meaningless.
          ifid_flush = 1'b1;
          if (flush_cnt <= 3'd1) begin
            flush_cnt_nxt = 3'd0;
            state_nxt     = RUN;
          end else begin
            flush_cnt_nxt = flush_cnt - 3'd1;
          end
        end
      end

      MEM_WAIT: begin
        if (mem_busy) begin
          pc_hold   = 1'b1;
          ifid_hold = 1'b1;
          ex_hold   = 1'b1;
          stall_inc = 1'b1;
        end else begin
          state_nxt = RUN;
        end
      end

      default: begin
        state_nxt = RUN;
        ret_nxt   = RUN;
      end
    endcase

    // During reset the pipe is filled with NOPs and nothing is held.
    if (rst) begin
      pc_hold     = 1'b0;
      ifid_hold   = 1'b0;
      ex_hold     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  // FSM state, return state and flush countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      ret_state <= RUN;
      flush_cnt <= 3'd0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // Free-running performance counters; they wrap at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count    <= '0;
      redirect_count <= '0;
    end else begin
      if (stall_inc)
        stall_count <= stall_count + CNT_ONE;
      if (redir_inc)
        redirect_count <= redirect_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. A driver applies one vector per cycle and
// queues the hand-derived control pattern and counter values. A monitor
// compares the DUT against the queue on the falling edge.
module tb_hazard_ctrl;

  localparam int CW = 4;

  localparam logic [31:0] NOP       = 32'h00000013;
  localparam logic [31:0] LW1       = 32'h0000A083; // lw x1,0(x1)
  localparam logic [31:0] LWX0      = 32'h0000A003; // lw x0,0(x1)
  localparam logic [31:0] ADD       = 32'h00108133; // add x2,x1,x1
  localparam logic [31:0] LW5       = 32'h00002283; // lw x5,0(x0)
  localparam logic [31:0] LUI5      = 32'h000052B7; // lui x5,5
  localparam logic [31:0] LUI_R5    = 32'h000280B7; // lui with [19:15]=5
  localparam logic [31:0] ADDI_R5   = 32'h00028093; // addi x1,x5,0
  localparam logic [31:0] SW_R5     = 32'h00502023; // sw x5,0(x0)
  localparam logic [31:0] ADDI_I5   = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] CSRRWI_5  = 32'h3002D073; // csrrwi, uimm=5
  localparam logic [31:0] CSRRW_R5  = 32'h30029073; // csrrw, rs1=x5

  // {pc_hold, ifid_hold, ifid_flush, idex_bubble, ex_hold}
  localparam logic [4:0] O_NONE = 5'b00000;
  localparam logic [4:0] O_LU   = 5'b11010;
  localparam logic [4:0] O_BR   = 5'b00110;
  localparam logic [4:0] O_FL   = 5'b00100;
  localparam logic [4:0] O_MB   = 5'b11001;
  localparam logic [4:0] O_RST  = 5'b00110;

  typedef struct {
    int          idx;
    logic [4:0]  outs;
    logic [CW-1:0] stall;
    logic [CW-1:0] redir;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [31:0]   id_inst;
  logic [31:0]   ex_inst;
  logic          br_taken;
  logic          mem_busy;
  logic          pc_hold;
  logic          ifid_hold;
  logic          ifid_flush;
  logic          idex_bubble;
  logic          ex_hold;
  logic [CW-1:0] stall_count;
  logic [CW-1:0] redirect_count;

  exp_t          sb[$];
  logic [CW-1:0] m_stall;
  logic [CW-1:0] m_redir;
  int            vidx;
  int            n_vec;
  int            n_bad;

  hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_inst        (id_inst),
    .ex_inst        (ex_inst),
    .br_taken       (br_taken),
    .mem_busy       (mem_busy),
    .pc_hold        (pc_hold),
    .ifid_hold      (ifid_hold),
    .ifid_flush     (ifid_flush),
    .idex_bubble    (idex_bubble),
    .ex_hold        (ex_hold),
    .stall_count    (stall_count),
    .redirect_count (redirect_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue what the DUT must show in that cycle.
  // Counters seen in this cycle reflect earlier increments; si/ri take effect
  // at the closing edge.
  task automatic vec(input logic [31:0] id, input logic [31:0] ex,
                     input logic br, input logic mb, input logic r,
                     input logic [4:0] eo, input logic si, input logic ri);
    exp_t e;
    @(posedge clk);
    #1;
    id_inst  = id;
    ex_inst  = ex;
    br_taken = br;
    mem_busy = mb;
    rst      = r;
    e.idx   = vidx;
    e.outs  = eo;
    e.stall = m_stall;
    e.redir = m_redir;
    sb.push_back(e);
    vidx = vidx + 1;
    if (r) begin
      m_stall = '0;
      m_redir = '0;
    end else begin
      m_stall = m_stall + {{(CW-1){1'b0}}, si};
      m_redir = m_redir + {{(CW-1){1'b0}}, ri};
    end
  endtask

  // Monitor: the DUT presents its controls every cycle; compare each queued one.
  initial begin
    exp_t e;
    logic [4:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {pc_hold, ifid_hold, ifid_flush, idex_bubble, ex_hold};
        n_vec = n_vec + 1;
        if (act !== e.outs || stall_count !== e.stall || redirect_count !== e.redir) begin
          n_bad = n_bad + 1;
          $display("FAIL vec%0d: ctrl act=%b req=%b stall act=%0d req=%0d redir act=%0d req=%0d",
                   e.idx, act, e.outs, stall_count, e.stall, redirect_count, e.redir);
        end
      end
    end
  end

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    vidx     = 0;
    m_stall  = '0;
    m_redir  = '0;
    rst      = 1'b1;
    id_inst  = NOP;
    ex_inst  = NOP;
    br_taken = 1'b0;
    mem_busy = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, then idle
    vec(NOP, NOP, 0, 0, 1, O_RST, 0, 0);
    vec(NOP, NOP, 0, 0, 0, O_NONE, 0, 0);

    // Load-use detection and its exclusions
    vec(ADD, LW1, 0, 0, 0, O_LU, 1, 0);
    vec(ADD, NOP, 0, 0, 0, O_NONE, 0, 0);
    vec(ADD, LWX0, 0, 0, 0, O_NONE, 0, 0);
    vec(LUI5, LW5, 0, 0, 0, O_NONE, 0, 0);
    vec(LUI_R5, LW5, 0, 0, 0, O_NONE, 0, 0);
    vec(ADDI_R5, LW5, 0, 0, 0, O_LU, 1, 0);
    vec(SW_R5, LW5, 0, 0, 0, O_LU, 1, 0);
    vec(ADDI_I5, LW5, 0, 0, 0, O_NONE, 0, 0);
    vec(CSRRWI_5, LW5, 0, 0, 0, O_NONE, 0, 0);
    vec(CSRRW_R5, LW5, 0, 0, 0, O_LU, 1, 0);

    // Redirect with two flush cycles
    vec(NOP, NOP, 1, 0, 0, O_BR, 0, 1);
    vec(NOP, NOP, 0, 0, 0, O_FL, 0, 0);
    vec(NOP, NOP, 0, 0, 0, O_NONE, 0, 0);

    // Redirect wins over a load-use pair; load-use ignored while flushing
    vec(ADD, LW1, 1, 0, 0, O_BR, 0, 1);
    vec(ADD, LW1, 0, 0, 0, O_FL, 0, 0);
    vec(NOP, NOP, 0, 0, 0, O_NONE, 0, 0);

    // br_taken ignored during FLUSH
    vec(NOP, NOP, 1, 0, 0, O_BR, 0, 1);
    vec(NOP, NOP, 1, 0, 0, O_FL, 0, 0);
    vec(NOP, NOP, 0, 0, 0, O_NONE, 0, 0);

    // mem_busy for 3 cycles in FLUSH with one flush cycle left
    vec(NOP, NOP, 1, 0, 0, O_BR, 0, 1);
    vec(NOP, NOP, 0, 1, 0, O_MB, 1, 0);
    vec(NOP, NOP, 0, 1, 0, O_MB, 1, 0);
    vec(NOP, NOP, 0, 1, 0, O_MB, 1, 0);
    vec(NOP, NOP, 0, 0, 0, O_FL, 0, 0);
    vec(NOP, NOP, 0, 0, 0, O_NONE, 0, 0);

    // mem_busy beats br_taken; branch acted on after returning to RUN
    vec(NOP, NOP, 1, 1, 0, O_MB, 1, 0);
    vec(NOP, NOP, 1, 1, 0, O_MB, 1, 0);
    vec(NOP, NOP, 1, 0, 0, O_BR, 0, 1);
    vec(NOP, NOP, 0, 0, 0, O_FL, 0, 0);
    vec(NOP, NOP, 0, 0, 0, O_NONE, 0, 0);

    // Returning to FLUSH: branch not acted on
    vec(NOP, NOP, 1, 0, 0, O_BR, 0, 1);
    vec(NOP, NOP, 1, 1, 0, O_MB, 1, 0);
    vec(NOP, NOP, 1, 0, 0, O_FL, 0, 0);
    vec(NOP, NOP, 0, 0, 0, O_NONE, 0, 0);

    // Load-use evaluated in the MEM_WAIT exit cycle
    vec(ADD, LW1, 0, 1, 0, O_MB, 1, 0);
    vec(ADD, LW1, 0, 0, 0, O_LU, 1, 0);
    vec(ADD, NOP, 0, 0, 0, O_NONE, 0, 0);

    // Reset mid-MEM_WAIT with mem_busy still high
    vec(NOP, NOP, 0, 1, 0, O_MB, 1, 0);
    vec(NOP, NOP, 0, 1, 1, O_RST, 0, 0);
    vec(NOP, NOP, 0, 0, 0, O_NONE, 0, 0);

    // Reset mid-FLUSH discards the pending flush
    vec(NOP, NOP, 1, 0, 0, O_BR, 0, 1);
    vec(NOP, NOP, 0, 0, 1, O_RST, 0, 0);
    vec(NOP, NOP, 0, 0, 0, O_NONE, 0, 0);

    // Redirect counter wraps after 2^CW redirects
    for (int i = 0; i < 16; i++) begin
      vec(NOP, NOP, 1, 0, 0, O_BR, 0, 1);
      vec(NOP, NOP, 0, 0, 0, O_FL, 0, 0);
    end
    vec(NOP, NOP, 0, 0, 0, O_NONE, 0, 0);

    // Stall counter wraps as well
    for (int i = 0; i < 17; i++)
      vec(NOP, NOP, 0, 1, 0, O_MB, 1, 0);
    vec(NOP, NOP, 0, 0, 0, O_NONE, 0, 0);
    vec(NOP, NOP, 0, 0, 0, O_NONE, 0, 0);

    for (int i = 0; i < 10 && sb.size() != 0; i++)
      @(posedge clk);
    if (sb.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL drain: pending act=%0d req=0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
